// File: rtl/tlb_op_sequencer.sv
// tlb_op_sequencer: multi-cycle sequencer for TLBP/TLBR/TLBWI/TLBWR between EX-stage decode
// and a single-port synchronous TLB entry array (read data valid one cycle after address).
//   clk/resetn          clock, async active-low reset
//   op_valid/tlb_type   op request ({tlbwr,tlbwi,tlbr,tlbp}); flush aborts any op in flight
//   *_i (CP0)           EntryHi/PageMask/EntryLo0/EntryLo1/Index/Random operands
//   tlb_*_o / tlb_r*_i  array address, write port and read data
//   stall_o, done_o     pipeline hold and 1-cycle completion pulse
//   probe_wen_o/read_wen_o + index_o/entry_hi_o/page_mask_o/entry_lo*_o  CP0 results
//   multi_hit_o         TLBP found >=2 matching entries
// Optional feature macro: TLB_MULTI_HIT_DETECT_EN (full scan with multi-hit detection);
// undefined: TLBP exits on the first hit and multi_hit_o is tied 0.
module tlb_op_sequencer #(
  parameter int unsigned TLB_LINE_NUM = 16,
  parameter int unsigned IDX_W        = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             op_valid,
  input  logic [3:0]       tlb_type,
  input  logic             flush,
  input  logic [31:0]      entry_hi_i,
  input  logic [31:0]      page_mask_i,
  input  logic [31:0]      entry_lo0_i,
  input  logic [31:0]      entry_lo1_i,
  input  logic [31:0]      index_i,
  input  logic [31:0]      random_i,
  output logic [IDX_W-1:0] tlb_idx_o,
  output logic             tlb_we_o,
  output logic [18:0]      tlb_wvpn2_o,
  output logic [7:0]       tlb_wasid_o,
  output logic [15:0]      tlb_wmask_o,
  output logic             tlb_wg_o,
  output logic [31:0]      tlb_wlo0_o,
  output logic [31:0]      tlb_wlo1_o,
  input  logic [18:0]      tlb_rvpn2_i,
  input  logic [7:0]       tlb_rasid_i,
  input  logic [15:0]      tlb_rmask_i,
  input  logic             tlb_rg_i,
  input  logic [31:0]      tlb_rlo0_i,
  input  logic [31:0]      tlb_rlo1_i,
  output logic             stall_o,
  output logic             done_o,
  output logic             probe_wen_o,
  output logic             read_wen_o,
  output logic [31:0]      index_o,
  output logic [31:0]      entry_hi_o,
  output logic [31:0]      page_mask_o,
  output logic [31:0]      entry_lo0_o,
  output logic [31:0]      entry_lo1_o,
  output logic             multi_hit_o
);

  typedef enum logic [2:0] {StIdle, StProbe, StRead, StRwait, StWrite, StDone} state_e;
  typedef enum logic [1:0] {OpProbe, OpRead, OpWrite} op_e;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [IDX_W:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [18:0]      vpn2_q, vpn2_d;
  logic [7:0]       asid_q, asid_d;
  logic [15:0]      mask_q, mask_d;
  logic [31:0]      lo0_q, lo0_d, lo1_q, lo1_d;
  logic [31:0]      index_q, index_d, rd_hi_q, rd_hi_d, rd_pm_q, rd_pm_d;
  logic [31:0]      rd_lo0_q, rd_lo0_d, rd_lo1_q, rd_lo1_d;
`ifdef TLB_MULTI_HIT_DETECT_EN
  logic             hit_q, hit_d, multi_q, multi_d;
  logic [IDX_W-1:0] hit_idx_q, hit_idx_d;
`endif

  logic             accept, match, cmp_valid, last;
  logic [IDX_W-1:0] cmp_idx;
  logic             unused_inputs;

  assign unused_inputs = ^{entry_hi_i[12:8], page_mask_i[31:29], page_mask_i[12:0],
                           index_i, random_i};

  assign accept    = (state_q == StIdle) && op_valid && (|tlb_type) && !flush;
  // Entry j-1 is on the read port while address j is driven.
  assign cmp_valid = (state_q == StProbe) && (cnt_q != '0);
  assign cmp_idx   = IDX_W'(cnt_q - 1'b1);
  assign last      = (cnt_q == (IDX_W+1)'(TLB_LINE_NUM));
  assign match     = (((tlb_rvpn2_i ^ vpn2_q) & ~{3'b0, tlb_rmask_i}) == '0) &&
                     (tlb_rg_i || (tlb_rasid_i == asid_q));

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    vpn2_d   = vpn2_q;
    asid_d   = asid_q;
    mask_d   = mask_q;
    lo0_d    = lo0_q;
    lo1_d    = lo1_q;
    index_d  = index_q;
    rd_hi_d  = rd_hi_q;
    rd_pm_d  = rd_pm_q;
    rd_lo0_d = rd_lo0_q;
    rd_lo1_d = rd_lo1_q;
`ifdef TLB_MULTI_HIT_DETECT_EN
    hit_d     = hit_q;
    multi_d   = multi_q;
    hit_idx_d = hit_idx_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          vpn2_d = entry_hi_i[31:13];
          asid_d = entry_hi_i[7:0];
          mask_d = page_mask_i[28:13];
          lo0_d  = entry_lo0_i;
          lo1_d  = entry_lo1_i;
          cnt_d  = '0;
          idx_d  = index_i[IDX_W-1:0];
`ifdef TLB_MULTI_HIT_DETECT_EN
          hit_d   = 1'b0;
          multi_d = 1'b0;
`endif
          if (tlb_type[0]) begin
            op_d    = OpProbe;
            state_d = StProbe;
          end else if (tlb_type[1]) begin
            op_d    = OpRead;
            state_d = StRead;
          end else begin
            op_d    = OpWrite;
            state_d = StWrite;
            if (!tlb_type[2]) idx_d = random_i[IDX_W-1:0];
          end
        end
      end
      StProbe: begin
        cnt_d = cnt_q + 1'b1;
`ifdef TLB_MULTI_HIT_DETECT_EN
        if (cmp_valid && match) begin
          if (!hit_q) begin
            hit_d     = 1'b1;
            hit_idx_d = cmp_idx;
          end else begin
            multi_d = 1'b1;
          end
        end
        if (last) begin
          state_d = StDone;
          index_d = hit_d ? {{(32-IDX_W){1'b0}}, hit_idx_d} : 32'h8000_0000;
        end
`else
        if (cmp_valid && match) begin
          state_d = StDone;
          index_d = {{(32-IDX_W){1'b0}}, cmp_idx};
        end else if (last) begin
          state_d = StDone;
          index_d = 32'h8000_0000;
        end
`endif
      end
      StRead:  state_d = StRwait;
      StRwait: begin
        state_d  = StDone;
        rd_hi_d  = {tlb_rvpn2_i, 5'b0, tlb_rasid_i};
        rd_pm_d  = {3'b0, tlb_rmask_i, 13'b0};
        rd_lo0_d = {tlb_rlo0_i[31:1], tlb_rg_i};
        rd_lo1_d = {tlb_rlo1_i[31:1], tlb_rg_i};
      end
      StWrite: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Abort: back to idle and leave the CP0 result registers untouched.
    if (flush && state_q != StIdle) begin
      state_d  = StIdle;
      index_d  = index_q;
      rd_hi_d  = rd_hi_q;
      rd_pm_d  = rd_pm_q;
      rd_lo0_d = rd_lo0_q;
      rd_lo1_d = rd_lo1_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      op_q     <= OpProbe;
      cnt_q    <= '0;
      idx_q    <= '0;
      vpn2_q   <= '0;
      asid_q   <= '0;
      mask_q   <= '0;
      lo0_q    <= '0;
      lo1_q    <= '0;
      index_q  <= '0;
      rd_hi_q  <= '0;
      rd_pm_q  <= '0;
      rd_lo0_q <= '0;
      rd_lo1_q <= '0;
`ifdef TLB_MULTI_HIT_DETECT_EN
      hit_q     <= 1'b0;
      multi_q   <= 1'b0;
      hit_idx_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      vpn2_q   <= vpn2_d;
      asid_q   <= asid_d;
      mask_q   <= mask_d;
      lo0_q    <= lo0_d;
      lo1_q    <= lo1_d;
      index_q  <= index_d;
      rd_hi_q  <= rd_hi_d;
      rd_pm_q  <= rd_pm_d;
      rd_lo0_q <= rd_lo0_d;
      rd_lo1_q <= rd_lo1_d;
`ifdef TLB_MULTI_HIT_DETECT_EN
      hit_q     <= hit_d;
      multi_q   <= multi_d;
      hit_idx_q <= hit_idx_d;
`endif
    end
  end

  always_comb begin
    tlb_idx_o = '0;
    unique case (state_q)
      StProbe:         tlb_idx_o = cnt_q[IDX_W-1:0];
      StRead, StWrite: tlb_idx_o = idx_q;
      default:         tlb_idx_o = '0;
    endcase
  end

  assign tlb_we_o    = (state_q == StWrite) && !flush;
  assign tlb_wmask_o = mask_q;
  assign tlb_wvpn2_o = vpn2_q & ~{3'b0, mask_q};
  assign tlb_wasid_o = asid_q;
  assign tlb_wg_o    = lo0_q[0] & lo1_q[0];
  assign tlb_wlo0_o  = lo0_q;
  assign tlb_wlo1_o  = lo1_q;

  assign stall_o     = accept || (state_q != StIdle && state_q != StDone);
  assign done_o      = (state_q == StDone) && !flush;
  assign probe_wen_o = done_o && (op_q == OpProbe);
  assign read_wen_o  = done_o && (op_q == OpRead);
  assign index_o     = index_q;
  assign entry_hi_o  = rd_hi_q;
  assign page_mask_o = rd_pm_q;
  assign entry_lo0_o = rd_lo0_q;
  assign entry_lo1_o = rd_lo1_q;
`ifdef TLB_MULTI_HIT_DETECT_EN
  assign multi_hit_o = probe_wen_o && multi_q;
`else
  assign multi_hit_o = 1'b0;
`endif

endmodule

// File: doc/tlb_op_sequencer.md
Name: tlb_op_sequencer

Overview:
Multi-cycle sequencer for TLBP/TLBR/TLBWI/TLBWR, sitting between the EX-stage decode (tlb_type) and a single-port synchronous TLB entry array. Scans the array one entry per cycle for TLBP, reads or writes one entry for the others, and stalls the pipeline while busy. Returns results in the CP0 register formats (Index, EntryHi, PageMask, EntryLo0/1) with a one-cycle result strobe that is the CP0 write enable.

Parameters:
TLB_LINE_NUM, 16, number of TLB entries (power of 2, 2..64)
IDX_W, 4, log2(TLB_LINE_NUM)

Ports:
clk  in  1  clock
resetn  in  1  async active-low reset
op_valid  in  1  TLB instruction present in EX and not stalled upstream
tlb_type  in  4  {tlbwr,tlbwi,tlbr,tlbp}
flush  in  1  pipeline flush; aborts current op
entry_hi_i  in  32  CP0 EntryHi (VPN2 31:13, ASID 7:0)
page_mask_i  in  32  CP0 PageMask (mask 28:13)
entry_lo0_i  in  32  CP0 EntryLo0
entry_lo1_i  in  32  CP0 EntryLo1
index_i  in  32  CP0 Index
random_i  in  32  CP0 Random
tlb_idx_o  out  IDX_W  array address
tlb_we_o  out  1  array write strobe
tlb_wvpn2_o  out  19  write VPN2
tlb_wasid_o  out  8  write ASID
tlb_wmask_o  out  16  write mask
tlb_wg_o  out  1  write G = lo0[0] & lo1[0]
tlb_wlo0_o  out  32  write EntryLo0
tlb_wlo1_o  out  32  write EntryLo1
tlb_rvpn2_i  in  19  read VPN2, valid 1 cycle after tlb_idx_o
tlb_rasid_i  in  8  read ASID
tlb_rmask_i  in  16  read mask
tlb_rg_i  in  1  read G
tlb_rlo0_i  in  32  read EntryLo0
tlb_rlo1_i  in  32  read EntryLo1
stall_o  out  1  hold pipeline
done_o  out  1  1-cycle completion pulse
probe_wen_o  out  1  write Index (pulse, TLBP)
read_wen_o  out  1  write EntryHi/PageMask/Lo0/Lo1 (pulse, TLBR)
index_o  out  32  TLBP result
entry_hi_o  out  32  TLBR EntryHi
page_mask_o  out  32  TLBR PageMask
entry_lo0_o  out  32  TLBR EntryLo0
entry_lo1_o  out  32  TLBR EntryLo1
multi_hit_o  out  1  see Optional Feature

Behaviour:
- Reset (async, resetn=0): state IDLE; all outputs 0.
- States: IDLE, PROBE, READ, RWAIT, WRITE, DONE.
- Accept in IDLE when op_valid & |tlb_type & ~flush. Priority if multiple bits: tlbp > tlbr > tlbwi > tlbwr. Latch entry_hi_i, page_mask_i, lo0/lo1 and target index (tlbwi: index_i[IDX_W-1:0]; tlbwr: random_i[IDX_W-1:0]).
- stall_o = (IDLE & accept) | (state ∉ {IDLE, DONE}). Low in DONE.
- WRITE (1 cycle): tlb_we_o=1 with latched fields, mask = page_mask[28:13], VPN2 = entry_hi[31:13] & ~{3'b0, mask}; then DONE. Accept at cycle 0 → we at 1 → done_o at 2.
- READ: drive idx. RWAIT: capture rdata into entry_hi_o = {rvpn2, 5'b0, rasid}, page_mask_o = {3'b0, rmask, 13'b0}, entry_lo0/1 = rlo with bit0 = rg. DONE: done_o=read_wen_o=1. Done at cycle 3.
- PROBE: counter j from 0 to TLB_LINE_NUM. Drives idx j (j<N) and compares the entry at j-1 (j≥1).
- Match = ((rvpn2 ^ vpn2_q) & ~{3'b0, rmask}) == 0 & (rg | rasid == asid_q).
- Hit on entry k → DONE with index_o = k. Done at cycle k+3.
- No hit after j=N → index_o = 32'h8000_0000. Done at cycle N+2.
- DONE: done_o=1 for one cycle (probe_wen_o for TLBP); → IDLE. No new accept in DONE.
- flush in any non-IDLE state → IDLE next cycle. No done/wen pulse. tlb_we_o forced 0 combinationally when flush. Result regs hold old values.
- index_o bits other than 31 and IDX_W-1:0 always 0.

Optional Feature:
TLB_MULTI_HIT_DETECT_EN. Defined: TLBP always scans all entries (done at N+2). index_o = lowest hit index. multi_hit_o pulses with done_o if ≥2 entries hit. Undefined: early exit on first hit; multi_hit_o tied 0.

Test Plan:
- TLBWI, index_i=5, entry_hi=0x0040_2011, page_mask=0, lo0=0x41, lo1=0x81 → tlb_we_o at cycle 1 with idx 5, vpn2=0x00201, asid 0x11, g=1, done_o at cycle 2; stall_o high cycles 0-1.
- TLBP after the above, entry_hi=0x0040_2099 → match via G; index_o=0x0000_0005; probe_wen_o at cycle 8 (early exit), or cycle 18 with TLB_MULTI_HIT_DETECT_EN.
- TLBP, all entries G=0 with ASID≠query → index_o=0x8000_0000, done at cycle 18.
- TLBR idx 5 where entry mask=0x0003 → page_mask_o=0x0000_6000, entry_hi_o VPN2 low 2 bits cleared, done_o at cycle 3.
- Flush asserted in cycle 4 of a TLBP → no done_o/probe_wen_o, state IDLE at 5, index_o unchanged; flush during WRITE → tlb_we_o stays 0.
- resetn low mid-PROBE → all outputs 0 immediately. Two entries hit (idx 2, 9) with TLB_MULTI_HIT_DETECT_EN → index_o=2, multi_hit_o=1.
